// File: rtl/instruction_fetch.sv
// RV32I instruction-fetch stage: owns the PC, keeps one instruction-memory
// request in flight and loads the IF/ID register consumed by decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_IR,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_valid
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        kill;
    logic [31:0] hold_ir;

    logic        deliver;
    logic [31:0] deliver_word;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_addr;

    assign pc_plus4      = pc + 32'd4;
    assign redirect_addr = {pc_target[31:2], 2'b00};

    assign imem_req  = (state == ST_REQ) && !rst;
    assign imem_addr = pc;

    // A redirect always wins over handing an instruction to decode.
    always_comb begin
        deliver      = 1'b0;
        deliver_word = imem_rdata;
        case (state)
            ST_WAIT: deliver = imem_rvalid && !kill && !stall && !pc_src;
            ST_HOLD: begin
                deliver      = !stall && !pc_src;
                deliver_word = hold_ir;
            end
            default: deliver = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_REQ;
            pc      <= RESET_PC;
            kill    <= 1'b0;
            hold_ir <= 32'd0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (pc_src)
                        pc <= redirect_addr;
                    if (imem_gnt) begin
                        state <= ST_WAIT;
                        // A redirect granted in the same cycle leaves a stale response in flight.
                        kill  <= pc_src;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state <= ST_REQ;
                        kill  <= 1'b0;
                        if (pc_src) begin
                            pc <= redirect_addr;
                        end else if (!kill) begin
                            if (stall) begin
                                hold_ir <= imem_rdata;
                                state   <= ST_HOLD;
                            end else begin
                                pc <= pc_plus4;
                            end
                        end
                    end else if (pc_src) begin
                        kill <= 1'b1;
                        pc   <= redirect_addr;
                    end
                end
                ST_HOLD: begin
                    if (pc_src) begin
                        pc    <= redirect_addr;
                        state <= ST_REQ;
                    end else if (!stall) begin
                        pc    <= pc_plus4;
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    // IF/ID register: flush beats stall beats normal loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IF_ID_IR    <= NOP;
            IF_ID_PC    <= 32'd0;
            IF_ID_PC4   <= 32'd0;
            IF_ID_valid <= 1'b0;
        end else if (flush) begin
            IF_ID_IR    <= NOP;
            IF_ID_PC    <= 32'd0;
            IF_ID_PC4   <= 32'd0;
            IF_ID_valid <= 1'b0;
        end else if (!stall) begin
            if (deliver) begin
                IF_ID_IR    <= deliver_word;
                IF_ID_PC    <= pc;
                IF_ID_PC4   <= pc_plus4;
                IF_ID_valid <= 1'b1;
            end else begin
                IF_ID_IR    <= NOP;
                IF_ID_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; a scoreboard queue holds the
// instructions expected in IF/ID and a negedge monitor retires them.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] IF_ID_IR;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_valid;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_valid = 1'b0;

    instruction_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .IF_ID_IR   (IF_ID_IR),
        .IF_ID_PC   (IF_ID_PC),
        .IF_ID_PC4  (IF_ID_PC4),
        .IF_ID_valid(IF_ID_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_insn(input logic [31:0] ir, input logic [31:0] pc);
        exp_t e;
        e.ir  = ir;
        e.pc  = pc;
        e.pc4 = pc + 32'd4;
        exp_q.push_back(e);
    endtask

    // Grant immediately, answer one cycle later with word w.
    task automatic fetch(input logic [31:0] w, input logic [31:0] pc);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = w;
        expect_insn(w, pc);
        tick();
        imem_rvalid = 1'b0;
    endtask

    // New instruction appears in IF/ID whenever valid rises.
    always @(negedge clk) begin
        if (IF_ID_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_insn: got IR %h PC %h, expected none", IF_ID_IR, IF_ID_PC);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ifid_ir", IF_ID_IR, e.ir);
                check("ifid_pc", IF_ID_PC, e.pc);
                check("ifid_pc4", IF_ID_PC4, e.pc4);
            end
        end
        prev_valid = IF_ID_valid;
    end

    initial begin
        tick();
        tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_ir", IF_ID_IR, NOP);
        check("rst_pc", IF_ID_PC, 32'd0);
        check("rst_pc4", IF_ID_PC4, 32'd0);
        check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);

        // Grant withheld for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nognt_req", {31'd0, imem_req}, 32'd1);
            check("nognt_addr", imem_addr, 32'h0);
            check("nognt_valid", {31'd0, IF_ID_valid}, 32'd0);
        end

        // Back-to-back fetch at 0 and 4 with a bubble between
        fetch(32'h0050_0093, 32'h0);
        check("seq_addr4", imem_addr, 32'h4);
        imem_gnt = 1'b1;
        tick();
        check("bubble_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("bubble_ir", IF_ID_IR, NOP);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A0_0113;
        expect_insn(32'h00A0_0113, 32'h4);
        tick();
        imem_rvalid = 1'b0;
        check("seq_addr8", imem_addr, 32'h8);

        // Stall when the response at 0x8 returns
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0033;
        stall       = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        check("hold_req", {31'd0, imem_req}, 32'd0);
        check("hold_valid", {31'd0, IF_ID_valid}, 32'd0);
        tick();
        check("hold2_req", {31'd0, imem_req}, 32'd0);
        check("hold2_valid", {31'd0, IF_ID_valid}, 32'd0);
        stall = 1'b0;
        expect_insn(32'h0000_0033, 32'h8);
        tick();
        check("after_hold_req", {31'd0, imem_req}, 32'd1);
        check("after_hold_addr", imem_addr, 32'hC);

        // Redirect to 0x103 while waiting on the response for 0xC
        imem_gnt = 1'b1;
        tick();
        imem_gnt  = 1'b0;
        pc_src    = 1'b1;
        pc_target = 32'h0000_0103;
        tick();
        pc_src = 1'b0;
        check("kill_wait_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("killed_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("redir_req", {31'd0, imem_req}, 32'd1);
        check("redir_addr", imem_addr, 32'h100);
        fetch(32'h0020_8193, 32'h100);
        check("redir_seq_addr", imem_addr, 32'h104);

        // Flush with stall plus redirect to the top word
        flush     = 1'b1;
        stall     = 1'b1;
        pc_src    = 1'b1;
        pc_target = 32'hFFFF_FFFC;
        tick();
        flush  = 1'b0;
        stall  = 1'b0;
        pc_src = 1'b0;
        check("flush_ir", IF_ID_IR, NOP);
        check("flush_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("flush_pc", IF_ID_PC, 32'd0);
        check("flush_pc4", IF_ID_PC4, 32'd0);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0030_0213, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);

        // Reset asserted mid-transaction with a valid instruction held in IF/ID
        fetch(32'h0040_0293, 32'h0);
        fetch(32'h0050_0313, 32'h4);
        stall    = 1'b1;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("arst_ir", IF_ID_IR, NOP);
        check("arst_pc", IF_ID_PC, 32'd0);
        check("arst_pc4", IF_ID_PC4, 32'd0);
        stall = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rerun_req", {31'd0, imem_req}, 32'd1);
        check("rerun_addr", imem_addr, 32'h0);
        fetch(32'h0060_0393, 32'h0);
        check("rerun_next_addr", imem_addr, 32'h4);

        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
